// File: rtl/score_bcd_display_pkg.sv
// Shared types and constants for the score BCD display: widths, FSM states,
// seven-segment codes and the double-dabble nibble adjust.
package score_bcd_display_pkg;

  localparam int unsigned SCORE_W    = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 3 * DIGIT_W;
  localparam int unsigned SHIFT_W    = BCD_W + SCORE_W;
  localparam int unsigned CONV_STEPS = 8;
  localparam int unsigned COUNT_W    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] hund;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_digits_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;

  // Add 3 to every BCD nibble that is 5 or more, ahead of a left shift
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic [DIGIT_W-1:0] nib;
    res = bcd;
    for (int i = 0; i < 3; i++) begin
      nib = bcd[i*DIGIT_W +: DIGIT_W];
      if (nib >= DIGIT_W'(5)) begin
        res[i*DIGIT_W +: DIGIT_W] = nib + DIGIT_W'(3);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/score_bcd_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module bcd_to_seg7
  import score_bcd_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_bcd_display.sv
// Watches the score bus and, on each change, runs an 8-step double-dabble
// conversion before registering new BCD digits and seven-segment codes.
module score_bcd_display
  import score_bcd_display_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] currScore,
  output logic [DIGIT_W-1:0] bcdHund,
  output logic [DIGIT_W-1:0] bcdTens,
  output logic [DIGIT_W-1:0] bcdOnes,
  output logic [SEG_W-1:0]   seg7Hund,
  output logic [SEG_W-1:0]   seg7Tens,
  output logic [SEG_W-1:0]   seg7Ones,
  output logic               convBusy,
  output logic               convDone
);

  localparam logic [SEG_W-1:0] SEG_LEAD_RST = BLANK_LEADING ? SEG_BLANK : SEG_0;

  state_t             state, state_nxt;
  logic [SCORE_W-1:0] last_score, last_score_nxt;
  logic [SHIFT_W-1:0] shifter, shifter_nxt;
  logic [COUNT_W-1:0] count, count_nxt;
  bcd_digits_t        digits, digits_nxt;
  logic [SEG_W-1:0]   seg_hund, seg_hund_nxt;
  logic [SEG_W-1:0]   seg_tens, seg_tens_nxt;
  logic [SEG_W-1:0]   seg_ones, seg_ones_nxt;
  logic               busy, busy_nxt;
  logic               done, done_nxt;

  logic [BCD_W-1:0]   adj_c;
  logic [SHIFT_W-1:0] shifted_c;
  bcd_digits_t        new_digits_c;
  logic               blank_hund_c;
  logic               blank_tens_c;
  logic [SEG_W-1:0]   dec_hund_c, dec_tens_c, dec_ones_c;

  // One double-dabble step: adjust the BCD field, then shift left by one
  assign adj_c        = add3_nibbles(shifter[SHIFT_W-1 -: BCD_W]);
  assign shifted_c    = {adj_c[BCD_W-2:0], shifter[SCORE_W-1:0], 1'b0};
  assign new_digits_c = bcd_digits_t'(shifted_c[SHIFT_W-1 -: BCD_W]);

  assign blank_hund_c = BLANK_LEADING && (new_digits_c.hund == '0);
  assign blank_tens_c = blank_hund_c && (new_digits_c.tens == '0);

  bcd_to_seg7 u_dec_hund (.digit(new_digits_c.hund), .blank(blank_hund_c), .seg_c(dec_hund_c));
  bcd_to_seg7 u_dec_tens (.digit(new_digits_c.tens), .blank(blank_tens_c), .seg_c(dec_tens_c));
  bcd_to_seg7 u_dec_ones (.digit(new_digits_c.ones), .blank(1'b0),         .seg_c(dec_ones_c));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_score <= '0;
      shifter    <= '0;
      count      <= '0;
      digits     <= '0;
      seg_hund   <= SEG_LEAD_RST;
      seg_tens   <= SEG_LEAD_RST;
      seg_ones   <= SEG_0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_score <= last_score_nxt;
      shifter    <= shifter_nxt;
      count      <= count_nxt;
      digits     <= digits_nxt;
      seg_hund   <= seg_hund_nxt;
      seg_tens   <= seg_tens_nxt;
      seg_ones   <= seg_ones_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_score_nxt = last_score;
    shifter_nxt    = shifter;
    count_nxt      = count;
    digits_nxt     = digits;
    seg_hund_nxt   = seg_hund;
    seg_tens_nxt   = seg_tens;
    seg_ones_nxt   = seg_ones;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (currScore != last_score) begin
          shifter_nxt    = {{BCD_W{1'b0}}, currScore};
          last_score_nxt = currScore;
          count_nxt      = '0;
          busy_nxt       = 1'b1;
          state_nxt      = CONV;
        end
      end
      CONV: begin
        shifter_nxt = shifted_c;
        count_nxt   = count + COUNT_W'(1);
        // Last shift: publish digits and segments together
        if (count == COUNT_W'(CONV_STEPS - 1)) begin
          digits_nxt   = new_digits_c;
          seg_hund_nxt = dec_hund_c;
          seg_tens_nxt = dec_tens_c;
          seg_ones_nxt = dec_ones_c;
          done_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end
      end
    endcase
  end

  assign bcdHund  = digits.hund;
  assign bcdTens  = digits.tens;
  assign bcdOnes  = digits.ones;
  assign seg7Hund = seg_hund;
  assign seg7Tens = seg_tens;
  assign seg7Ones = seg_ones;
  assign convBusy = busy;
  assign convDone = done;

endmodule

// File: tb/tb_score_bcd_display.sv
// Self-checking bench for score_bcd_display against a decimal-arithmetic model.
module tb_score_bcd_display;

  logic       clk;
  logic       rst;
  logic [7:0] currScore;
  logic [3:0] bcdHund, bcdTens, bcdOnes;
  logic [6:0] seg7Hund, seg7Tens, seg7Ones;
  logic       convBusy, convDone;

  int checks = 0;
  int fails  = 0;
  int disp_val = 0;

  logic [6:0]  seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [32:0] obs;

  assign obs = {bcdHund, bcdTens, bcdOnes, seg7Hund, seg7Tens, seg7Ones};

  score_bcd_display #(.BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .currScore(currScore),
    .bcdHund(bcdHund), .bcdTens(bcdTens), .bcdOnes(bcdOnes),
    .seg7Hund(seg7Hund), .seg7Tens(seg7Tens), .seg7Ones(seg7Ones),
    .convBusy(convBusy), .convDone(convDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hund,tens,ones,segH,segT,segO} for a displayed score
  function automatic logic [32:0] exp_out(input int v);
    int h, t, o;
    logic [6:0] sh, st, so;
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    sh = (h == 0) ? 7'h7F : seg_tab[h];
    st = (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
    so = seg_tab[o];
    return {4'(h), 4'(t), 4'(o), sh, st, so};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    currScore = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (obs !== exp_out(0)) begin fails++; $display("FAIL reset_outputs got %h want %h", obs, exp_out(0)); end
    checks++; if ({convBusy, convDone} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {convBusy, convDone}); end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (obs !== exp_out(0) || convBusy !== 1'b0 || convDone !== 1'b0) begin
        fails++; $display("FAIL reset_idle cyc %0d got %h busy %b done %b want %h 0 0", i, obs, convBusy, convDone, exp_out(0));
      end
    end
    disp_val = 0;
  endtask

  // Drive one new score and check the full E0..E9 timeline
  task automatic test_convert(input int v);
    if (v == disp_val) return;
    currScore = 8'(v);
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        checks++; if (convBusy !== 1'b1 || convDone !== 1'b0 || obs !== exp_out(disp_val)) begin
          fails++; $display("FAIL conv_%0d_E%0d got busy %b done %b out %h want 1 0 %h", v, c, convBusy, convDone, obs, exp_out(disp_val));
        end
      end else if (c == 8) begin
        checks++; if (convBusy !== 1'b0 || convDone !== 1'b1 || obs !== exp_out(v)) begin
          fails++; $display("FAIL conv_%0d_E8 got busy %b done %b out %h want 0 1 %h", v, convBusy, convDone, obs, exp_out(v));
        end
      end else begin
        checks++; if (convBusy !== 1'b0 || convDone !== 1'b0 || obs !== exp_out(v)) begin
          fails++; $display("FAIL conv_%0d_E9 got busy %b done %b out %h want 0 0 %h", v, convBusy, convDone, obs, exp_out(v));
        end
      end
    end
    disp_val = v;
  endtask

  task automatic test_basic();
    test_convert(11);
    checks++; if (seg7Tens !== 7'h79 || seg7Hund !== 7'h7F) begin fails++; $display("FAIL basic_11_segs got %h %h want 7f 79", seg7Hund, seg7Tens); end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 255));
      if (v == disp_val) v = (v + 1) % 256;
      test_convert(v);
    end
  endtask

  task automatic test_boundaries();
    test_convert(255);
    test_convert(100);
    checks++; if (seg7Tens !== 7'h40) begin fails++; $display("FAIL tens_zero_lit got %h want 40", seg7Tens); end
  endtask

  task automatic test_change_during_conv();
    int pulses = 0;
    int start_val;
    start_val = disp_val;
    currScore = 8'd10;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      checks++; if (convDone !== ((c == 8) || (c == 17))) begin
        fails++; $display("FAIL chg_done cyc %0d got %b want %b", c, convDone, (c == 8) || (c == 17));
      end
      if (convDone === 1'b1) pulses++;
      if (c < 8) begin
        checks++; if (obs !== exp_out(start_val)) begin fails++; $display("FAIL chg_hold cyc %0d got %h want %h", c, obs, exp_out(start_val)); end
      end
      if (c == 8) begin
        checks++; if (obs !== exp_out(10)) begin fails++; $display("FAIL chg_first got %h want %h", obs, exp_out(10)); end
      end
      if (c == 17) begin
        checks++; if (obs !== exp_out(9)) begin fails++; $display("FAIL chg_second got %h want %h", obs, exp_out(9)); end
      end
      if (c == 2) currScore = 8'd9;
    end
    checks++; if (pulses != 2) begin fails++; $display("FAIL chg_pulse_count got %0d want 2", pulses); end
    disp_val = 9;
  endtask

  task automatic test_reset_mid_conv();
    int n;
    bit found;
    currScore = 8'd200;
    @(posedge clk); #1;
    checks++; if (convBusy !== 1'b1) begin fails++; $display("FAIL rmid_start busy got %b want 1", convBusy); end
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (obs !== exp_out(0) || convBusy !== 1'b0 || convDone !== 1'b0) begin
      fails++; $display("FAIL rmid_async got %h busy %b done %b want %h 0 0", obs, convBusy, convDone, exp_out(0));
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (convDone !== 1'b0 || obs !== exp_out(0)) begin fails++; $display("FAIL rmid_held got done %b out %h want 0 %h", convDone, obs, exp_out(0)); end
    end
    rst = 1'b1;
    disp_val = 0;
    found = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge clk); #1;
      if (convDone === 1'b1) begin found = 1'b1; n = c; end
    end
    checks++; if (!found || n != 8) begin fails++; $display("FAIL rmid_reconv found %b at %0d want 1 at 8", found, n); end
    checks++; if (obs !== exp_out(200)) begin fails++; $display("FAIL rmid_value got %h want %h", obs, exp_out(200)); end
    disp_val = 200;
  endtask

  task automatic test_no_change();
    int busy_seen = 0;
    int done_seen = 0;
    currScore = 8'(disp_val + 1);
    #2 currScore = 8'(disp_val);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (convBusy === 1'b1) busy_seen++;
      if (convDone === 1'b1) done_seen++;
    end
    checks++; if (busy_seen != 0 || done_seen != 0) begin fails++; $display("FAIL nochg busy %0d done %0d want 0 0", busy_seen, done_seen); end
    checks++; if (obs !== exp_out(disp_val)) begin fails++; $display("FAIL nochg_hold got %h want %h", obs, exp_out(disp_val)); end
  endtask

  // Score-keeper sweep 0->11->0, one step every 3 clocks
  task automatic test_sweep();
    int hist[$];
    bit ok;
    test_convert(0);
    for (int c = 0; c < 86; c++) begin
      if (c < 66 && c % 3 == 0) currScore = 8'((c / 3 < 11) ? (c / 3 + 1) : (21 - c / 3));
      hist.push_back(int'(currScore));
      if (hist.size() > 18) void'(hist.pop_front());
      @(posedge clk); #1;
      checks++; if (!(bcdHund <= 4'd2 && bcdTens <= 4'd9 && bcdOnes <= 4'd9)) begin
        fails++; $display("FAIL sweep_legal cyc %0d got %h %h %h", c, bcdHund, bcdTens, bcdOnes);
      end
      if (convDone === 1'b1) begin
        ok = 1'b0;
        foreach (hist[i]) if (!ok && obs === exp_out(hist[i])) begin ok = 1'b1; disp_val = hist[i]; end
        checks++; if (!ok) begin fails++; $display("FAIL sweep_lag cyc %0d got %h not a recent score", c, obs); end
      end else begin
        checks++; if (obs !== exp_out(disp_val)) begin fails++; $display("FAIL sweep_hold cyc %0d got %h want %h", c, obs, exp_out(disp_val)); end
      end
    end
    checks++; if (obs !== exp_out(0) || convBusy !== 1'b0) begin fails++; $display("FAIL sweep_final got %h busy %b want %h 0", obs, convBusy, exp_out(0)); end
    checks++; if (seg7Ones !== 7'h40) begin fails++; $display("FAIL sweep_ones got %h want 40", seg7Ones); end
  endtask

  initial begin
    rst = 1'b0;
    currScore = 8'd0;
    test_reset();
    test_basic();
    test_random();
    test_boundaries();
    test_change_during_conv();
    test_reset_mid_conv();
    test_no_change();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
